// File: rtl/nmea_feed_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nmea_feed_sequencer
//  Description : Captures one NMEA sentence ($...*HH) from the UART byte
//                stream, verifies its XOR checksum, and replays clean
//                sentences to the GPS parser after a parser reset pulse,
//                at a paced byte rate. Then it waits, with a timeout, for
//                the parser's fix and publishes that fix atomically.
//  Revision    : 1.0  initial release
// ============================================================================
module nmea_feed_sequencer #(
    parameter int BUF_DEPTH  = 96,   // max body bytes between '$' and '*'
    parameter int GAP_CYCLES = 2,    // idle cycles after each replayed byte
    parameter int TIMEOUT    = 64    // cycles to wait for parser data_ready
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  p_data_o,
    output logic        p_valid_o,
    output logic        p_rst_o,
    input  logic        p_data_ready_i,
    input  logic [15:0] p_lat_deg_i,
    input  logic [15:0] p_lat_min_i,
    input  logic [23:0] p_lon_deg_i,
    input  logic [15:0] p_lon_min_i,
    output logic [15:0] fix_lat_deg_o,
    output logic [15:0] fix_lat_min_o,
    output logic [23:0] fix_lon_deg_o,
    output logic [15:0] fix_lon_min_o,
    output logic        fix_valid_o,
    output logic        busy_o,
    output logic        err_checksum_o,
    output logic        err_overflow_o,
    output logic        err_timeout_o,
    output logic [15:0] sentence_count_o
);

    localparam int ADDR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PTR_W  = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W  = $clog2(BUF_DEPTH + 3);
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [7:0] c_DOLLAR = 8'h24;
    localparam logic [7:0] c_STAR   = 8'h2A;
    localparam logic [7:0] c_COMMA  = 8'h2C;

    typedef enum logic [2:0] {
        S_HUNT       = 3'd0,
        S_CAPTURE    = 3'd1,
        S_CSUM_HI    = 3'd2,
        S_CSUM_LO    = 3'd3,
        S_REPLAY_RST = 3'd4,
        S_REPLAY     = 3'd5,
        S_WAIT_READY = 3'd6
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [7:0]          csum_acc_q;
    logic [3:0]          csum_hi_q;
    logic [IDX_W-1:0]    idx_q;
    logic [GAP_W-1:0]    gap_q;
    logic [TMO_W-1:0]    timer_q;
    logic                flag_q;

    logic [15:0]         sh_lat_deg_q;
    logic [15:0]         sh_lat_min_q;
    logic [23:0]         sh_lon_deg_q;
    logic [15:0]         sh_lon_min_q;

    logic [7:0]          p_data_q;
    logic                p_valid_q;
    logic                p_rst_q;
    logic [15:0]         fix_lat_deg_q;
    logic [15:0]         fix_lat_min_q;
    logic [23:0]         fix_lon_deg_q;
    logic [15:0]         fix_lon_min_q;
    logic                fix_valid_q;
    logic                err_checksum_q;
    logic                err_overflow_q;
    logic                err_timeout_q;
    logic [15:0]         sentence_count_q;

    logic [7:0]          buf_q [BUF_DEPTH];

    logic                w_hex_ok;
    logic [3:0]          w_hex_val;
    logic                w_buf_we;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [IDX_W-1:0]    w_rd_full;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [IDX_W-1:0]    w_last_idx;
    logic                w_ptr_full;

    // Decode the incoming byte as an ASCII hex digit (either case).
    always_comb begin
        w_hex_ok  = 1'b0;
        w_hex_val = 4'h0;
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            w_hex_ok  = 1'b1;
            w_hex_val = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            w_hex_ok  = 1'b1;
            w_hex_val = rx_data_i[3:0] + 4'd9;
        end
    end

    // Buffer addressing: body byte k of the replay lives at buf[k-1];
    // the replay index runs 0 ('$') .. ptr+1 (',').
    always_comb begin
        w_ptr_full = (ptr_q == PTR_W'(BUF_DEPTH));
        w_buf_we   = (state_q == S_CAPTURE) && rx_valid_i &&
                     (rx_data_i != c_STAR) && (rx_data_i != c_DOLLAR) && !w_ptr_full;
        w_wr_addr  = ptr_q[ADDR_W-1:0];
        w_rd_full  = idx_q - IDX_W'(1);
        w_rd_addr  = w_rd_full[ADDR_W-1:0];
        w_last_idx = IDX_W'(ptr_q) + IDX_W'(1);
    end

    // Line buffer storage; contents are only meaningful below ptr, so no reset.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            buf_q[w_wr_addr] <= rx_data_i;
        end
    end

    // Main sequencer: capture, checksum check, paced replay, fix publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_HUNT;
            ptr_q            <= '0;
            csum_acc_q       <= '0;
            csum_hi_q        <= '0;
            idx_q            <= '0;
            gap_q            <= '0;
            timer_q          <= '0;
            flag_q           <= 1'b0;
            sh_lat_deg_q     <= '0;
            sh_lat_min_q     <= '0;
            sh_lon_deg_q     <= '0;
            sh_lon_min_q     <= '0;
            p_data_q         <= '0;
            p_valid_q        <= 1'b0;
            p_rst_q          <= 1'b0;
            fix_lat_deg_q    <= '0;
            fix_lat_min_q    <= '0;
            fix_lon_deg_q    <= '0;
            fix_lon_min_q    <= '0;
            fix_valid_q      <= 1'b0;
            err_checksum_q   <= 1'b0;
            err_overflow_q   <= 1'b0;
            err_timeout_q    <= 1'b0;
            sentence_count_q <= '0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle.
            p_valid_q      <= 1'b0;
            p_rst_q        <= 1'b0;
            fix_valid_q    <= 1'b0;
            err_checksum_q <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;

            // The parser may finish while bytes are still being fed; remember
            // the most recent fix it presents until we can publish it.
            if ((state_q == S_REPLAY || state_q == S_WAIT_READY) && p_data_ready_i) begin
                flag_q       <= 1'b1;
                sh_lat_deg_q <= p_lat_deg_i;
                sh_lat_min_q <= p_lat_min_i;
                sh_lon_deg_q <= p_lon_deg_i;
                sh_lon_min_q <= p_lon_min_i;
            end

            case (state_q)
                S_HUNT: begin
                    if (rx_valid_i && rx_data_i == c_DOLLAR) begin
                        ptr_q      <= '0;
                        csum_acc_q <= '0;
                        state_q    <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == c_STAR) begin
                            state_q <= S_CSUM_HI;
                        end else if (rx_data_i == c_DOLLAR) begin
                            // A fresh start marker abandons the partial sentence.
                            ptr_q      <= '0;
                            csum_acc_q <= '0;
                        end else if (w_ptr_full) begin
                            err_overflow_q <= 1'b1;
                            state_q        <= S_HUNT;
                        end else begin
                            csum_acc_q <= csum_acc_q ^ rx_data_i;
                            ptr_q      <= ptr_q + PTR_W'(1);
                        end
                    end
                end

                S_CSUM_HI: begin
                    if (rx_valid_i) begin
                        if (w_hex_ok) begin
                            csum_hi_q <= w_hex_val;
                            state_q   <= S_CSUM_LO;
                        end else begin
                            err_checksum_q <= 1'b1;
                            state_q        <= S_HUNT;
                        end
                    end
                end

                S_CSUM_LO: begin
                    if (rx_valid_i) begin
                        if (w_hex_ok && ({csum_hi_q, w_hex_val} == csum_acc_q)) begin
                            p_rst_q <= 1'b1;
                            state_q <= S_REPLAY_RST;
                        end else begin
                            err_checksum_q <= 1'b1;
                            state_q        <= S_HUNT;
                        end
                    end
                end

                S_REPLAY_RST: begin
                    // Parser is being cleared this cycle; lead with '$' next.
                    flag_q    <= 1'b0;
                    p_valid_q <= 1'b1;
                    p_data_q  <= c_DOLLAR;
                    idx_q     <= IDX_W'(1);
                    gap_q     <= '0;
                    state_q   <= S_REPLAY;
                end

                S_REPLAY: begin
                    if (gap_q == GAP_W'(GAP_CYCLES)) begin
                        if (idx_q <= w_last_idx) begin
                            p_valid_q <= 1'b1;
                            p_data_q  <= (idx_q == w_last_idx) ? c_COMMA : buf_q[w_rd_addr];
                            idx_q     <= idx_q + IDX_W'(1);
                            gap_q     <= '0;
                        end else begin
                            timer_q <= '0;
                            state_q <= S_WAIT_READY;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end

                S_WAIT_READY: begin
                    if (flag_q) begin
                        fix_lat_deg_q    <= sh_lat_deg_q;
                        fix_lat_min_q    <= sh_lat_min_q;
                        fix_lon_deg_q    <= sh_lon_deg_q;
                        fix_lon_min_q    <= sh_lon_min_q;
                        fix_valid_q      <= 1'b1;
                        sentence_count_q <= sentence_count_q + 16'd1;
                        state_q          <= S_HUNT;
                    end else if (!p_data_ready_i) begin
                        // A fix arriving on the last cycle wins over the timeout.
                        if (timer_q == TMO_W'(TIMEOUT - 1)) begin
                            err_timeout_q <= 1'b1;
                            state_q       <= S_HUNT;
                        end else begin
                            timer_q <= timer_q + TMO_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= S_HUNT;
                end
            endcase
        end
    end

    assign busy_o           = (state_q == S_REPLAY_RST) || (state_q == S_REPLAY) ||
                              (state_q == S_WAIT_READY);
    assign p_data_o         = p_data_q;
    assign p_valid_o        = p_valid_q;
    assign p_rst_o          = p_rst_q;
    assign fix_lat_deg_o    = fix_lat_deg_q;
    assign fix_lat_min_o    = fix_lat_min_q;
    assign fix_lon_deg_o    = fix_lon_deg_q;
    assign fix_lon_min_o    = fix_lon_min_q;
    assign fix_valid_o      = fix_valid_q;
    assign err_checksum_o   = err_checksum_q;
    assign err_overflow_o   = err_overflow_q;
    assign err_timeout_o    = err_timeout_q;
    assign sentence_count_o = sentence_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nmea_feed_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nmea_feed_sequencer
//  Description : Directed self-checking bench for nmea_feed_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nmea_feed_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  p_data;
    logic        p_valid;
    logic        p_rst;
    logic        p_data_ready = 1'b0;
    logic [15:0] p_lat_deg = 16'd0;
    logic [15:0] p_lat_min = 16'd0;
    logic [23:0] p_lon_deg = 24'd0;
    logic [15:0] p_lon_min = 16'd0;
    logic [15:0] fix_lat_deg;
    logic [15:0] fix_lat_min;
    logic [23:0] fix_lon_deg;
    logic [15:0] fix_lon_min;
    logic        fix_valid;
    logic        busy;
    logic        err_checksum;
    logic        err_overflow;
    logic        err_timeout;
    logic [15:0] sentence_count;

    nmea_feed_sequencer #(
        .BUF_DEPTH  (96),
        .GAP_CYCLES (2),
        .TIMEOUT    (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data_i        (rx_data),
        .rx_valid_i       (rx_valid),
        .p_data_o         (p_data),
        .p_valid_o        (p_valid),
        .p_rst_o          (p_rst),
        .p_data_ready_i   (p_data_ready),
        .p_lat_deg_i      (p_lat_deg),
        .p_lat_min_i      (p_lat_min),
        .p_lon_deg_i      (p_lon_deg),
        .p_lon_min_i      (p_lon_min),
        .fix_lat_deg_o    (fix_lat_deg),
        .fix_lat_min_o    (fix_lat_min),
        .fix_lon_deg_o    (fix_lon_deg),
        .fix_lon_min_o    (fix_lon_min),
        .fix_valid_o      (fix_valid),
        .busy_o           (busy),
        .err_checksum_o   (err_checksum),
        .err_overflow_o   (err_overflow),
        .err_timeout_o    (err_timeout),
        .sentence_count_o (sentence_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nerr = 0;
    int last_n = 0;
    int excl_bad = 0;

    int          pv_cyc[$];
    logic [7:0]  pv_dat[$];
    int          prst_cyc[$];
    int          fixv_cyc[$];
    int          eck_cyc[$];
    int          eov_cyc[$];
    int          eto_cyc[$];

    string GGA_BODY = "GPGGA,123519,3130,N,12024,E";

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (p_valid) begin
            pv_cyc.push_back(cyc);
            pv_dat.push_back(p_data);
        end
        if (p_rst)        prst_cyc.push_back(cyc);
        if (fix_valid)    fixv_cyc.push_back(cyc);
        if (err_checksum) eck_cyc.push_back(cyc);
        if (err_overflow) eov_cyc.push_back(cyc);
        if (err_timeout)  eto_cyc.push_back(cyc);
        if ((int'(fix_valid) + int'(err_checksum) + int'(err_overflow) + int'(err_timeout)) > 1)
            excl_bad++;
    end

    task automatic clear_logs();
        @(negedge clk); #1;
        pv_cyc.delete(); pv_dat.delete(); prst_cyc.delete(); fixv_cyc.delete();
        eck_cyc.delete(); eov_cyc.delete(); eto_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        last_n   = cyc;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Parser model: raises data_ready with the given fix once nb bytes were fed.
    task automatic parser_respond(input int nb, input logic [15:0] ld, input logic [15:0] lm,
                                  input logic [23:0] od, input logic [15:0] om);
        int t;
        t = 0;
        while (pv_cyc.size() < nb && t < 400) begin @(negedge clk); #1; t++; end
        nvec++;
        if (pv_cyc.size() < nb) begin
            $display("FAIL parser_wait: saw %0d bytes, required %0d", pv_cyc.size(), nb); nerr++;
        end
        p_lat_deg = ld; p_lat_min = lm; p_lon_deg = od; p_lon_min = om;
        p_data_ready = 1'b1;
        t = 0;
        while (fixv_cyc.size() == 0 && t < 200) begin @(negedge clk); #1; t++; end
        nvec++;
        if (fixv_cyc.size() == 0) begin
            $display("FAIL fix_wait: no fix_valid within 200 cycles"); nerr++;
        end
        p_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        nvec++;
        if ({p_valid, p_rst, fix_valid, busy, err_checksum, err_overflow, err_timeout} !== 7'b0) begin
            $display("FAIL reset_strobes: got %b required 0000000",
                     {p_valid, p_rst, fix_valid, busy, err_checksum, err_overflow, err_timeout});
            nerr++;
        end
        nvec++;
        if (p_data !== 8'h00 || sentence_count !== 16'd0 || fix_lat_deg !== 16'd0 || fix_lon_deg !== 24'd0) begin
            $display("FAIL reset_data: p_data=%h count=%0d lat=%0d lon=%0d required all 0",
                     p_data, sentence_count, fix_lat_deg, fix_lon_deg);
            nerr++;
        end
        @(negedge clk); rst = 1'b0;
        idle(2);
        nvec++;
        if (busy !== 1'b0 || p_valid !== 1'b0) begin
            $display("FAIL reset_release: busy=%b p_valid=%b required 0/0", busy, p_valid); nerr++;
        end
    endtask

    task automatic test_bad_checksum();
        int n0;
        clear_logs();
        send_str({"$", GGA_BODY, "*49"});
        n0 = last_n;
        idle(10);
        nvec++;
        if (eck_cyc.size() != 1 || eck_cyc[0] != n0 + 1) begin
            $display("FAIL bad_csum_pulse: count %0d at %0d, required 1 at %0d",
                     eck_cyc.size(), (eck_cyc.size() > 0) ? eck_cyc[0] : -1, n0 + 1);
            nerr++;
        end
        nvec++;
        if (prst_cyc.size() != 0 || pv_cyc.size() != 0) begin
            $display("FAIL bad_csum_replay: p_rst %0d p_valid %0d, required 0/0", prst_cyc.size(), pv_cyc.size());
            nerr++;
        end
        nvec++;
        if (fix_lat_deg !== 16'd0 || fix_lon_deg !== 24'd0 || sentence_count !== 16'd0) begin
            $display("FAIL bad_csum_fix: lat=%0d lon=%0d count=%0d required 0/0/0", fix_lat_deg, fix_lon_deg, sentence_count);
            nerr++;
        end
    endtask

    task automatic test_clean();
        int    n0;
        string exp_s;
        clear_logs();
        exp_s = {"$", GGA_BODY, ","};
        send_str({"$", GGA_BODY, "*48"});
        n0 = last_n;
        parser_respond(29, 16'd31, 16'd30, 24'd120, 16'd24);
        idle(5);
        nvec++;
        if (prst_cyc.size() != 1 || prst_cyc[0] != n0 + 1) begin
            $display("FAIL clean_p_rst: count %0d at %0d, required 1 at %0d",
                     prst_cyc.size(), (prst_cyc.size() > 0) ? prst_cyc[0] : -1, n0 + 1);
            nerr++;
        end
        nvec++;
        if (pv_cyc.size() != 29) begin
            $display("FAIL clean_byte_count: got %0d required 29", pv_cyc.size()); nerr++;
        end
        for (int k = 0; k < 29; k++) begin
            int         ac;
            logic [7:0] ad;
            ac = (k < pv_cyc.size()) ? pv_cyc[k] : -1;
            ad = (k < pv_dat.size()) ? pv_dat[k] : 8'hxx;
            nvec++;
            if (ac != n0 + 2 + 3 * k || ad !== exp_s[k]) begin
                $display("FAIL clean_byte%0d: cycle %0d data %h, required cycle %0d data %h",
                         k, ac, ad, n0 + 2 + 3 * k, exp_s[k]);
                nerr++;
            end
        end
        nvec++;
        if (fixv_cyc.size() != 1 || fixv_cyc[0] != n0 + 90) begin
            $display("FAIL clean_fix_valid: count %0d at %0d, required 1 at %0d",
                     fixv_cyc.size(), (fixv_cyc.size() > 0) ? fixv_cyc[0] : -1, n0 + 90);
            nerr++;
        end
        nvec++;
        if (fix_lat_deg !== 16'd31 || fix_lat_min !== 16'd30 || fix_lon_deg !== 24'd120 || fix_lon_min !== 16'd24) begin
            $display("FAIL clean_fix: got %0d,%0d,%0d,%0d required 31,30,120,24",
                     fix_lat_deg, fix_lat_min, fix_lon_deg, fix_lon_min);
            nerr++;
        end
        nvec++;
        if (sentence_count !== 16'd1) begin
            $display("FAIL clean_count: got %0d required 1", sentence_count); nerr++;
        end
        nvec++;
        if (eck_cyc.size() + eov_cyc.size() + eto_cyc.size() != 0) begin
            $display("FAIL clean_errors: got %0d error pulses required 0",
                     eck_cyc.size() + eov_cyc.size() + eto_cyc.size());
            nerr++;
        end
    endtask

    task automatic test_overflow();
        int n_ov;
        clear_logs();
        send_byte(8'h24);
        for (int i = 0; i < 97; i++) send_byte(8'h41);
        n_ov = last_n;
        idle(3);
        nvec++;
        if (eov_cyc.size() != 1 || eov_cyc[0] != n_ov + 1) begin
            $display("FAIL overflow_pulse: count %0d at %0d, required 1 at %0d",
                     eov_cyc.size(), (eov_cyc.size() > 0) ? eov_cyc[0] : -1, n_ov + 1);
            nerr++;
        end
        nvec++;
        if (busy !== 1'b0 || eck_cyc.size() != 0) begin
            $display("FAIL overflow_state: busy=%b err_checksum=%0d required 0/0", busy, eck_cyc.size()); nerr++;
        end
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        parser_respond(29, 16'd45, 16'd12, 24'd7, 16'd59);
        idle(3);
        nvec++;
        if (sentence_count !== 16'd2 || fix_lat_deg !== 16'd45 || fix_lon_min !== 16'd59) begin
            $display("FAIL overflow_recover: count=%0d lat=%0d lonmin=%0d required 2/45/59",
                     sentence_count, fix_lat_deg, fix_lon_min);
            nerr++;
        end
    endtask

    task automatic test_timeout();
        int n0;
        int t;
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        n0 = last_n;
        t = 0;
        while (eto_cyc.size() == 0 && t < 400) begin @(negedge clk); #1; t++; end
        idle(3);
        nvec++;
        if (eto_cyc.size() != 1 || eto_cyc[0] != n0 + 153) begin
            $display("FAIL timeout_pulse: count %0d at %0d, required 1 at %0d",
                     eto_cyc.size(), (eto_cyc.size() > 0) ? eto_cyc[0] : -1, n0 + 153);
            nerr++;
        end
        nvec++;
        if (fixv_cyc.size() != 0 || sentence_count !== 16'd2 || fix_lat_deg !== 16'd45) begin
            $display("FAIL timeout_fix: fix_valid %0d count %0d lat %0d required 0/2/45",
                     fixv_cyc.size(), sentence_count, fix_lat_deg);
            nerr++;
        end
        nvec++;
        if (busy !== 1'b0) begin
            $display("FAIL timeout_busy: got %b required 0", busy); nerr++;
        end
    endtask

    task automatic test_restart();
        int n0;
        clear_logs();
        send_str("$GP");
        send_str({"$", GGA_BODY, "*48"});
        n0 = last_n;
        parser_respond(29, 16'd10, 16'd20, 24'd30, 16'd40);
        idle(3);
        nvec++;
        if (pv_cyc.size() != 29 || prst_cyc.size() != 1 || prst_cyc[0] != n0 + 1) begin
            $display("FAIL restart_replay: bytes %0d p_rst %0d, required 29 and 1 at %0d",
                     pv_cyc.size(), prst_cyc.size(), n0 + 1);
            nerr++;
        end
        nvec++;
        if (sentence_count !== 16'd3 || fix_lat_deg !== 16'd10 || fix_lon_min !== 16'd40) begin
            $display("FAIL restart_fix: count=%0d lat=%0d lonmin=%0d required 3/10/40",
                     sentence_count, fix_lat_deg, fix_lon_min);
            nerr++;
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        nvec++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_rise: got %b required 1", busy); nerr++;
        end
        send_str({"$", GGA_BODY, "*48"});
        parser_respond(29, 16'd1, 16'd2, 24'd3, 16'd4);
        idle(150);
        nvec++;
        if (pv_cyc.size() != 29 || prst_cyc.size() != 1 || fixv_cyc.size() != 1) begin
            $display("FAIL busy_drop: bytes %0d p_rst %0d fix_valid %0d required 29/1/1",
                     pv_cyc.size(), prst_cyc.size(), fixv_cyc.size());
            nerr++;
        end
        nvec++;
        if (sentence_count !== 16'd4) begin
            $display("FAIL busy_count: got %0d required 4", sentence_count); nerr++;
        end
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        parser_respond(29, 16'd5, 16'd6, 24'd7, 16'd8);
        idle(3);
        nvec++;
        if (sentence_count !== 16'd5 || fix_lat_deg !== 16'd5 || fix_lat_min !== 16'd6 ||
            fix_lon_deg !== 24'd7 || fix_lon_min !== 16'd8) begin
            $display("FAIL after_busy_fix: count=%0d fix=%0d,%0d,%0d,%0d required 5 and 5,6,7,8",
                     sentence_count, fix_lat_deg, fix_lat_min, fix_lon_deg, fix_lon_min);
            nerr++;
        end
    endtask

    task automatic test_mid_reset();
        int t;
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        t = 0;
        while (pv_cyc.size() < 11 && t < 200) begin @(negedge clk); #1; t++; end
        nvec++;
        if (pv_cyc.size() != 11 || p_valid !== 1'b1) begin
            $display("FAIL midrst_reach: bytes %0d p_valid %b, required 11 and 1", pv_cyc.size(), p_valid); nerr++;
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({p_valid, p_rst, busy, fix_valid} !== 4'b0 || p_data !== 8'h00 ||
            sentence_count !== 16'd0 || fix_lat_deg !== 16'd0 || fix_lon_deg !== 24'd0) begin
            $display("FAIL midrst_async: pv=%b prst=%b busy=%b data=%h count=%0d lat=%0d required all 0",
                     p_valid, p_rst, busy, p_data, sentence_count, fix_lat_deg);
            nerr++;
        end
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        idle(100);
        nvec++;
        if (pv_cyc.size() != 11) begin
            $display("FAIL midrst_silence: bytes %0d required 11", pv_cyc.size()); nerr++;
        end
        clear_logs();
        send_str({"$", GGA_BODY, "*48"});
        parser_respond(29, 16'd31, 16'd30, 24'd120, 16'd24);
        idle(3);
        nvec++;
        if (sentence_count !== 16'd1 || fix_lat_deg !== 16'd31 || fix_lon_deg !== 24'd120 || pv_cyc.size() != 29) begin
            $display("FAIL midrst_recover: count=%0d lat=%0d lon=%0d bytes=%0d required 1/31/120/29",
                     sentence_count, fix_lat_deg, fix_lon_deg, pv_cyc.size());
            nerr++;
        end
    endtask

    initial begin
        test_reset();
        test_bad_checksum();
        test_clean();
        test_overflow();
        test_timeout();
        test_restart();
        test_back_to_back();
        test_mid_reset();
        nvec++;
        if (excl_bad !== 0) begin
            $display("FAIL pulse_exclusive: %0d cycles with overlapping pulses, required 0", excl_bad); nerr++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
